pid_pwm_driver: RTL and testbench

//  Downstream stage of the servo PID. Converts the signed pid_output sample into a

---
 rtl/servo_pkg.sv | 15 +
 rtl/pwm_period_counter.sv | 34 +++
 rtl/pid_pwm_driver.sv | 139 +++++++++++++
 tb/tb_pid_pwm_driver.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared servo constants and PWM driver state encoding
// Purpose: default widths/timing for the servo PWM path and the driver FSM states.
// Ports: none (package).
package servo_pkg;
  localparam int DEF_DATA_W        = 18;
  localparam int DEF_CNT_W         = 12;
  localparam int DEF_PERIOD_CYCLES = 2000;
  localparam int DEF_SHIFT         = 6;
  localparam int DEF_DEAD_CYCLES   = 20;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DEAD = 1'b1
  } pwm_state_t;
endpackage

// File: rtl/pwm_period_counter.sv
// rtl/pwm_period_counter.sv - free-running PWM period counter with wrap pulse
// Purpose: counts 0..PERIOD_CYCLES-1 and wraps; flags the last cycle of each period.
// Ports:
//   sclk        in   system clock
//   rst         in   synchronous active-high reset
//   cnt_next    out  value cnt takes at the next edge (lets the top register
//                    its PWM compare against the upcoming count)
//   period_tick out  high while cnt == PERIOD_CYCLES-1 (the wrap cycle)
module pwm_period_counter #(
  parameter int CNT_W         = servo_pkg::DEF_CNT_W,
  parameter int PERIOD_CYCLES = servo_pkg::DEF_PERIOD_CYCLES
) (
  input  logic             sclk,
  input  logic             rst,
  output logic [CNT_W-1:0] cnt_next,
  output logic             period_tick
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  assign cnt_next = (cnt == LAST) ? '0 : cnt + CNT_W'(1);

  // period_tick is registered from cnt_next, so it is high exactly while cnt == LAST.
  always_ff @(posedge sclk) begin
    if (rst) begin
      cnt         <= '0;
      period_tick <= 1'b0;
    end else begin
      cnt         <= cnt_next;
      period_tick <= (cnt_next == LAST);
    end
  end
endmodule

// File: rtl/pid_pwm_driver.sv
// rtl/pid_pwm_driver.sv - PID output to direction + fixed-period PWM with dead time
// Purpose: converts signed PID effort into |u|>>SHIFT duty (clamped) plus direction,
//   holds each sample pending until the period boundary, and forces PWM low for
//   DEAD_CYCLES after a direction reversal.
// Ports:
//   sclk        in   system clock
//   rst         in   synchronous active-high reset
//   u_in        in   signed control effort (two's complement, DATA_W bits)
//   u_valid     in   one-cycle strobe qualifying u_in
//   pwm_out     out  H-bridge enable PWM
//   dir_out     out  0 = forward, 1 = reverse
//   period_tick out  one-cycle pulse on the last cycle of each period
//   sat_flag    out  applied duty is clamped to PERIOD_CYCLES
module pid_pwm_driver #(
  parameter int DATA_W        = servo_pkg::DEF_DATA_W,
  parameter int CNT_W         = servo_pkg::DEF_CNT_W,
  parameter int PERIOD_CYCLES = servo_pkg::DEF_PERIOD_CYCLES,
  parameter int SHIFT         = servo_pkg::DEF_SHIFT,
  parameter int DEAD_CYCLES   = servo_pkg::DEF_DEAD_CYCLES
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic [DATA_W-1:0] u_in,
  input  logic              u_valid,
  output logic              pwm_out,
  output logic              dir_out,
  output logic              period_tick,
  output logic              sat_flag
);
  import servo_pkg::*;

  localparam logic [DATA_W-1:0] PER_D     = DATA_W'(PERIOD_CYCLES);
  localparam logic [CNT_W-1:0]  PER_C     = CNT_W'(PERIOD_CYCLES);
  localparam logic [CNT_W-1:0]  DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);

  logic [CNT_W-1:0] cnt_next;

  pwm_period_counter #(
    .CNT_W        (CNT_W),
    .PERIOD_CYCLES(PERIOD_CYCLES)
  ) u_counter (
    .sclk       (sclk),
    .rst        (rst),
    .cnt_next   (cnt_next),
    .period_tick(period_tick)
  );

  // Conversion: -2**(DATA_W-1) negates to itself, which read unsigned is 2**(DATA_W-1).
  logic [DATA_W-1:0] mag, mag_sh;
  logic [CNT_W-1:0]  duty_new;
  logic              sat_new;

  assign mag      = u_in[DATA_W-1] ? -u_in : u_in;
  assign mag_sh   = mag >> SHIFT;
  assign sat_new  = (mag_sh > PER_D);
  assign duty_new = sat_new ? PER_C : mag_sh[CNT_W-1:0];

  pwm_state_t       state, state_d;
  logic [CNT_W-1:0] dcnt, dcnt_d;
  logic [CNT_W-1:0] duty_act, duty_act_d, duty_pend, duty_pend_d;
  logic             dir_act, dir_act_d, dir_pend, dir_pend_d;
  logic             sat_act, sat_act_d, sat_pend, sat_pend_d;
  logic             pend, pend_d;
  logic             pwm_d;

  always_ff @(posedge sclk) begin
    if (rst) begin
      state     <= ST_RUN;
      dcnt      <= '0;
      duty_act  <= '0;
      dir_act   <= 1'b0;
      sat_act   <= 1'b0;
      pend      <= 1'b0;
      duty_pend <= '0;
      dir_pend  <= 1'b0;
      sat_pend  <= 1'b0;
      pwm_out   <= 1'b0;
    end else begin
      state     <= state_d;
      dcnt      <= dcnt_d;
      duty_act  <= duty_act_d;
      dir_act   <= dir_act_d;
      sat_act   <= sat_act_d;
      pend      <= pend_d;
      duty_pend <= duty_pend_d;
      dir_pend  <= dir_pend_d;
      sat_pend  <= sat_pend_d;
      pwm_out   <= pwm_d;
    end
  end

  always_comb begin
    state_d     = state;
    dcnt_d      = dcnt;
    duty_act_d  = duty_act;
    dir_act_d   = dir_act;
    sat_act_d   = sat_act;
    pend_d      = pend;
    duty_pend_d = duty_pend;
    dir_pend_d  = dir_pend;
    sat_pend_d  = sat_pend;

    case (state)
      ST_RUN: begin
        if (period_tick && pend) begin
          duty_act_d = duty_pend;
          dir_act_d  = dir_pend;
          sat_act_d  = sat_pend;
          pend_d     = 1'b0;
          if (dir_pend != dir_act) begin
            state_d = ST_DEAD;
            dcnt_d  = '0;
          end
        end
      end
      ST_DEAD: begin
        if (dcnt == DEAD_LAST) state_d = ST_RUN;
        else                   dcnt_d  = dcnt + CNT_W'(1);
      end
      default: state_d = ST_RUN;
    endcase

    // Evaluated after the boundary load so a strobe on the wrap cycle is kept
    // pending for the following boundary instead of being consumed now.
    if (u_valid) begin
      duty_pend_d = duty_new;
      dir_pend_d  = u_in[DATA_W-1];
      sat_pend_d  = sat_new;
      pend_d      = 1'b1;
    end

    // Compare against next-cycle count/state so the registered PWM lines up
    // with cnt: new duty shows at cnt=0, post-reversal rise at cnt=DEAD_CYCLES.
    pwm_d = (state_d == ST_RUN) && (cnt_next < duty_act_d);
  end

  assign dir_out  = dir_act;
  assign sat_flag = sat_act;
endmodule

// File: tb/tb_pid_pwm_driver.sv
// tb/tb_pid_pwm_driver.sv - directed self-checking bench for pid_pwm_driver
// Purpose: drives hand-picked PID samples and checks PWM timing, direction,
//   saturation, period tick and reset behaviour against hand-computed values.
// Ports: none (testbench top).
module tb_pid_pwm_driver;
  localparam int PER = 2000;

  logic        sclk = 1'b0;
  logic        rst = 1'b1;
  logic [17:0] u_in = '0;
  logic        u_valid = 1'b0;
  logic        pwm_out, dir_out, period_tick, sat_flag;

  int n_tests = 0;
  int n_fail  = 0;
  int ph      = 0;   // bench's own copy of the period count
  int hi, first, n;

  pid_pwm_driver #(
    .DATA_W(18), .CNT_W(12), .PERIOD_CYCLES(PER), .SHIFT(6), .DEAD_CYCLES(20)
  ) dut (
    .sclk(sclk), .rst(rst), .u_in(u_in), .u_valid(u_valid),
    .pwm_out(pwm_out), .dir_out(dir_out), .period_tick(period_tick), .sat_flag(sat_flag)
  );

  always #5 sclk = ~sclk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic cycle();
    logic r;
    r = rst;
    @(posedge sclk);
    #1;
    ph = r ? 0 : ((ph == PER - 1) ? 0 : ph + 1);
  endtask

  task automatic goto_ph(input int target);
    while (ph != target) cycle();
  endtask

  task automatic strobe(input int v);
    u_in    = v[17:0];
    u_valid = 1'b1;
    cycle();
    u_valid = 1'b0;
  endtask

  // Samples a whole period starting at the current cycle (expected ph == 0).
  task automatic measure(output int h, output int f);
    h = 0;
    f = -1;
    for (int i = 0; i < PER; i++) begin
      if (pwm_out === 1'b1) begin
        h++;
        if (f < 0) f = i;
      end
      if (i < PER - 1) cycle();
    end
  endtask

  task automatic apply_and_measure(input string tag, input int v, input int exp_hi,
                                   input int exp_dir, input int exp_sat);
    goto_ph(500);
    strobe(v);
    goto_ph(0);
    check({tag, "_dir"}, dir_out, exp_dir);
    check({tag, "_sat"}, sat_flag, exp_sat);
    measure(hi, first);
    check({tag, "_high"}, hi, exp_hi);
  endtask

  initial begin
    // 1: reset
    rst = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    check("rst_pwm", pwm_out, 0);
    check("rst_dir", dir_out, 0);
    check("rst_sat", sat_flag, 0);
    check("rst_tick", period_tick, 0);
    rst = 1'b0;
    n = 0;
    while (period_tick !== 1'b1 && n < PER + 100) begin
      cycle();
      n++;
    end
    // Last reset edge leaves cnt=0; cnt reaches PER-1 after PER-1 further edges.
    check("tick_first", n, PER - 1);
    cycle();
    check("tick_one_cycle", period_tick, 0);

    // 2: +64000 -> 1000 cycles high, forward, not saturated
    goto_ph(500);
    strobe(64000);
    goto_ph(1999);
    check("pend_not_early", pwm_out, 0);
    cycle();
    check("fwd_dir", dir_out, 0);
    check("fwd_sat", sat_flag, 0);
    measure(hi, first);
    check("fwd_high", hi, 1000);
    check("fwd_first", first, 0);

    // 3: -131072 -> reverse, dead time 20, then saturated full-on
    goto_ph(500);
    strobe(-131072);
    goto_ph(0);
    check("rev_dir", dir_out, 1);
    check("rev_sat", sat_flag, 1);
    measure(hi, first);
    check("rev_high", hi, PER - 20);
    check("rev_first", first, 20);
    cycle();
    measure(hi, first);
    check("rev_full_high", hi, PER);

    // 4: latest strobe wins (+640 then +6400 -> duty 100, reversal to forward)
    goto_ph(100);
    strobe(640);
    goto_ph(200);
    strobe(6400);
    goto_ph(0);
    check("two_dir", dir_out, 0);
    measure(hi, first);
    check("two_high", hi, 80);
    check("two_first", first, 20);
    // ph is now PER-1: strobe on the wrap cycle
    strobe(32000);
    measure(hi, first);
    check("wrap_strobe_held", hi, 100);
    cycle();
    measure(hi, first);
    check("wrap_strobe_applied", hi, 500);

    // 5: conversion boundaries
    apply_and_measure("u128000", 128000, 2000, 0, 0);
    apply_and_measure("u63", 63, 0, 0, 0);
    apply_and_measure("u128064", 128064, 2000, 0, 1);
    apply_and_measure("u0", 0, 0, 0, 0);

    // 6a: reset during dead time discards pending sample
    goto_ph(500);
    strobe(-64000);
    goto_ph(5);
    check("dead_pwm_low", pwm_out, 0);
    check("dead_dir_rev", dir_out, 1);
    strobe(6400);
    rst = 1'b1;
    cycle();
    check("rst_dead_pwm", pwm_out, 0);
    check("rst_dead_dir", dir_out, 0);
    check("rst_dead_tick", period_tick, 0);
    rst = 1'b0;
    cycle();
    goto_ph(0);
    measure(hi, first);
    check("rst_dead_discard", hi, 0);
    check("rst_dead_dir_after", dir_out, 0);

    // 6b: reset during a high pulse
    goto_ph(500);
    strobe(64000);
    goto_ph(10);
    check("pulse_high", pwm_out, 1);
    strobe(6400);
    rst = 1'b1;
    cycle();
    check("rst_pulse_pwm", pwm_out, 0);
    check("rst_pulse_sat", sat_flag, 0);
    rst = 1'b0;
    cycle();
    goto_ph(0);
    measure(hi, first);
    check("rst_pulse_discard", hi, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
